// File: rtl/hbm_dma_fetch.sv
// rtl/hbm_dma_fetch.sv - DMA read fetcher: chunked read commands, credit-gated FIFO, consumer stream
//
// Purpose:
//   On a start pulse, reads a contiguous host region [addr_x, addr_x + length)
//   by issuing chunk-sized DMA read commands. The returned 512-bit beats are
//   buffered in an internal FIFO and forwarded to the HBM consumer. A command
//   is only issued once FIFO credit covers the whole chunk, so the FIFO can
//   never overflow.
//
// Optional feature (macro HBM_FETCH_LAST_CHECK_EN):
//   Tracks the beat count of every issued command (up to 4 outstanding) and
//   sets a sticky err when tlast is early or missing. Without the macro no
//   tracker exists and err is tied 0.
//
// Ports:
//   hbm_clk, hbm_areset            clock, asynchronous active-high reset
//   m_axis_dma_read_cmd_*          read command: tvalid/tready, address(64), length(32)
//   s_axis_dma_read_data_*         read data: tvalid/tready, tdata(512), tkeep(64), tlast
//   start, addr_x, data_length     transfer request (sampled on start, length[5:0] masked)
//   out_data, out_valid            beat to consumer, 1 cycle after FIFO pop
//   out_almost_full                consumer backpressure
//   busy, done, err                status (done pulses with the final out_valid)

module hbm_dma_fetch #(
   parameter int CHUNK_BYTES = 4096,
   parameter int FIFO_DEPTH  = 256
) (
   input  logic         hbm_clk,
   input  logic         hbm_areset,

   output logic         m_axis_dma_read_cmd_tvalid,
   input  logic         m_axis_dma_read_cmd_tready,
   output logic [63:0]  m_axis_dma_read_cmd_address,
   output logic [31:0]  m_axis_dma_read_cmd_length,

   input  logic         s_axis_dma_read_data_tvalid,
   output logic         s_axis_dma_read_data_tready,
   input  logic [511:0] s_axis_dma_read_data_tdata,
   input  logic [63:0]  s_axis_dma_read_data_tkeep,
   input  logic         s_axis_dma_read_data_tlast,

   input  logic         start,
   input  logic [63:0]  addr_x,
   input  logic [31:0]  data_length,

   output logic [511:0] out_data,
   output logic         out_valid,
   input  logic         out_almost_full,

   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] CHUNK_LEN = 32'(CHUNK_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WAIT_CREDIT,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t       state_q, state_d;
   logic [63:0]  addr_q, addr_d;
   logic [31:0]  remaining_q, remaining_d;
   logic [31:0]  cmd_len_q, cmd_len_d;
   logic [CNT_W-1:0] cmd_beats_q, cmd_beats_d;
   logic [CNT_W-1:0] free_credit_q, free_credit_d;
   logic [25:0]  total_beats_q, total_beats_d;
   logic [25:0]  popped_q, popped_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         zero_q, zero_d;

   logic [511:0] out_data_q;
   logic         out_valid_q;

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] fifo_cnt_q;
   logic [511:0]     fifo_mem [FIFO_DEPTH];

   logic         start_ok;
   logic [31:0]  len_masked;
   logic         reserve;
   logic         busy_set;
   logic         last_pop;
   logic         cmd_valid;
   logic         cmd_hs;
   logic         fifo_full, fifo_empty;
   logic         push, pop;
   logic         trk_full;

   assign len_masked = {data_length[31:6], 6'd0};
   // zero_q/done_q keep a zero-length request from being re-armed while its done is pending
   assign start_ok   = start & ~busy_q & ~zero_q & ~done_q;

   assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt_q == '0);
   assign push       = s_axis_dma_read_data_tvalid & s_axis_dma_read_data_tready;
   assign pop        = ~fifo_empty & ~out_almost_full;
   assign cmd_hs     = cmd_valid & m_axis_dma_read_cmd_tready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge hbm_clk or posedge hbm_areset) begin
      if (hbm_areset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      cmd_len_d     = cmd_len_q;
      cmd_beats_d   = cmd_beats_q;
      total_beats_d = total_beats_q;
      reserve       = 1'b0;
      busy_set      = 1'b0;
      zero_d        = 1'b0;
      cmd_valid     = 1'b0;
      last_pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               addr_d        = addr_x;
               remaining_d   = len_masked;
               total_beats_d = data_length[31:6];
               if (len_masked != 32'd0) begin
                  state_d  = S_CALC;
                  busy_set = 1'b1;
               end else begin
                  zero_d = 1'b1;
               end
            end
         end
         S_CALC: begin
            cmd_len_d   = (remaining_q > CHUNK_LEN) ? CHUNK_LEN : remaining_q;
            cmd_beats_d = CNT_W'(cmd_len_d >> 6);
            state_d     = S_WAIT_CREDIT;
         end
         S_WAIT_CREDIT: begin
            if (free_credit_q >= cmd_beats_q) begin
               reserve = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // trk_full only ever asserts when the tlast tracker is built
            cmd_valid = ~trk_full;
            if (cmd_valid && m_axis_dma_read_cmd_tready) begin
               addr_d      = addr_q + {32'd0, cmd_len_q};
               remaining_d = remaining_q - cmd_len_q;
               state_d     = (remaining_q == cmd_len_q) ? S_DRAIN : S_CALC;
            end
         end
         S_DRAIN: begin
            if (pop && (popped_q + 26'd1 == total_beats_q)) begin
               last_pop = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_comb begin
      free_credit_d = free_credit_q
                    - (reserve ? cmd_beats_q : '0)
                    + (pop ? CNT_W'(1) : '0);
      popped_d      = start_ok ? 26'd0 : (popped_q + (pop ? 26'd1 : 26'd0));
      // done is registered so it lines up with the registered out_valid of the final beat
      done_d        = last_pop | zero_q;
      busy_d        = busy_set ? 1'b1 : (done_q ? 1'b0 : busy_q);
   end

   always_ff @(posedge hbm_clk or posedge hbm_areset) begin
      if (hbm_areset) begin
         addr_q        <= '0;
         remaining_q   <= '0;
         cmd_len_q     <= '0;
         cmd_beats_q   <= '0;
         free_credit_q <= CNT_W'(FIFO_DEPTH);
         total_beats_q <= '0;
         popped_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         zero_q        <= 1'b0;
      end else begin
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         cmd_len_q     <= cmd_len_d;
         cmd_beats_q   <= cmd_beats_d;
         free_credit_q <= free_credit_d;
         total_beats_q <= total_beats_d;
         popped_q      <= popped_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         zero_q        <= zero_d;
      end
   end

   // -------------------------------------------------------------- FIFO
   always_ff @(posedge hbm_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= s_axis_dma_read_data_tdata;
      end
   end

   always_ff @(posedge hbm_clk or posedge hbm_areset) begin
      if (hbm_areset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q   <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            out_data_q <= fifo_mem[rd_ptr_q];
         end
         fifo_cnt_q  <= fifo_cnt_q + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);
         out_valid_q <= pop;
      end
   end

   // ------------------------------------------------------ tlast tracker
`ifdef HBM_FETCH_LAST_CHECK_EN
   logic [CNT_W-1:0] trk_mem [4];
   logic [1:0]       trk_wr_q, trk_rd_q;
   logic [2:0]       trk_cnt_q;
   logic [CNT_W-1:0] trk_beat_q;
   logic             err_q;
   logic             trk_have, beat_final, trk_pop;

   assign trk_full   = (trk_cnt_q == 3'd4);
   assign trk_have   = (trk_cnt_q != 3'd0);
   assign beat_final = trk_have && (trk_beat_q + CNT_W'(1) == trk_mem[trk_rd_q]);
   assign trk_pop    = push & beat_final;

   always_ff @(posedge hbm_clk) begin
      if (cmd_hs) begin
         trk_mem[trk_wr_q] <= cmd_beats_q;
      end
   end

   always_ff @(posedge hbm_clk or posedge hbm_areset) begin
      if (hbm_areset) begin
         trk_wr_q   <= '0;
         trk_rd_q   <= '0;
         trk_cnt_q  <= '0;
         trk_beat_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (cmd_hs) begin
            trk_wr_q <= trk_wr_q + 2'd1;
         end
         if (trk_pop) begin
            trk_rd_q <= trk_rd_q + 2'd1;
         end
         trk_cnt_q <= trk_cnt_q + (cmd_hs ? 3'd1 : 3'd0) - (trk_pop ? 3'd1 : 3'd0);
         if (push && trk_have) begin
            trk_beat_q <= beat_final ? '0 : trk_beat_q + CNT_W'(1);
            if (s_axis_dma_read_data_tlast != beat_final) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign err = err_q;

   logic unused_ok;
   assign unused_ok = ^{s_axis_dma_read_data_tkeep, data_length[5:0]};
`else
   assign trk_full = 1'b0;
   assign err      = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{s_axis_dma_read_data_tkeep, s_axis_dma_read_data_tlast,
                        data_length[5:0], cmd_hs};
`endif

   // ----------------------------------------------------------- outputs
   assign m_axis_dma_read_cmd_tvalid  = cmd_valid;
   assign m_axis_dma_read_cmd_address = addr_q;
   assign m_axis_dma_read_cmd_length  = cmd_len_q;
   assign s_axis_dma_read_data_tready = busy_q & ~fifo_full;
   assign out_data                    = out_data_q;
   assign out_valid                   = out_valid_q;
   assign busy                        = busy_q;
   assign done                        = done_q;

endmodule

// File: tb/tb_hbm_dma_fetch.sv
// tb/tb_hbm_dma_fetch.sv - directed self-checking bench for hbm_dma_fetch

module tb_hbm_dma_fetch;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid, cmd_ready;
   logic [63:0]  cmd_addr;
   logic [31:0]  cmd_len;
   logic         d_tvalid, d_tready, d_tlast;
   logic [511:0] d_tdata;
   logic [63:0]  d_tkeep;
   logic         start;
   logic [63:0]  addr_x;
   logic [31:0]  data_length;
   logic [511:0] out_data;
   logic         out_valid, almost_full, busy, done, err;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   hbm_dma_fetch #(.CHUNK_BYTES(4096), .FIFO_DEPTH(256)) dut (
      .hbm_clk                    (clk),
      .hbm_areset                 (rst),
      .m_axis_dma_read_cmd_tvalid (cmd_valid),
      .m_axis_dma_read_cmd_tready (cmd_ready),
      .m_axis_dma_read_cmd_address(cmd_addr),
      .m_axis_dma_read_cmd_length (cmd_len),
      .s_axis_dma_read_data_tvalid(d_tvalid),
      .s_axis_dma_read_data_tready(d_tready),
      .s_axis_dma_read_data_tdata (d_tdata),
      .s_axis_dma_read_data_tkeep (d_tkeep),
      .s_axis_dma_read_data_tlast (d_tlast),
      .start                      (start),
      .addr_x                     (addr_x),
      .data_length                (data_length),
      .out_data                   (out_data),
      .out_valid                  (out_valid),
      .out_almost_full            (almost_full),
      .busy                       (busy),
      .done                       (done),
      .err                        (err)
   );

   // host memory model: each beat carries its own byte address replicated 8x
   logic [63:0] q_addr[$];
   logic [31:0] q_len[$];
   logic [63:0] log_addr[$];
   logic [31:0] log_len[$];
   int          inject_last_at = -1;
   int          beat_i, cur_beats;
   logic [63:0] cur_addr, ba;
   bit          active, fire;

   initial begin
      d_tvalid = 1'b0; d_tdata = '0; d_tlast = 1'b0; d_tkeep = '1;
      active = 1'b0; fire = 1'b0; beat_i = 0; cur_beats = 0; cur_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q_addr.delete(); q_len.delete();
            active = 1'b0; fire = 1'b0; d_tvalid = 1'b0; d_tlast = 1'b0;
            continue;
         end
         if (fire) begin
            beat_i++;
            if (beat_i == cur_beats) active = 1'b0;
         end
         if (!active && q_addr.size() > 0) begin
            cur_addr  = q_addr.pop_front();
            cur_beats = int'(q_len.pop_front() / 64);
            beat_i    = 0;
            active    = 1'b1;
         end
         d_tvalid = active;
         if (active) begin
            ba      = cur_addr + 64'(64 * beat_i);
            d_tdata = {8{ba}};
            d_tlast = (beat_i == cur_beats - 1) || (beat_i == inject_last_at);
         end else begin
            d_tdata = '0;
            d_tlast = 1'b0;
         end
         fire = d_tvalid && d_tready;
         if (cmd_valid && cmd_ready) begin
            q_addr.push_back(cmd_addr);  q_len.push_back(cmd_len);
            log_addr.push_back(cmd_addr); log_len.push_back(cmd_len);
         end
      end
   end

   // consumer-side monitor
   logic [63:0] mon_base = '0;
   logic [63:0] exp_a;
   int exp_total = 0;
   int out_beats = 0, data_bad = 0, done_cnt = 0, done_on_last = 0;
   int busy_seen = 0, cmdv_seen = 0, err_seen = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (out_valid) begin
            exp_a = mon_base + 64'(64 * out_beats);
            if (out_data !== {8{exp_a}}) data_bad++;
            out_beats++;
         end
         if (done) begin
            done_cnt++;
            if (out_valid && out_beats == exp_total) done_on_last++;
         end
         if (busy) busy_seen++;
         if (cmd_valid) cmdv_seen++;
         if (err !== 1'b0) err_seen++;
      end
   end

   task automatic clear_mon(input logic [63:0] base, input int total);
      mon_base = base; exp_total = total;
      out_beats = 0; data_bad = 0; done_cnt = 0; done_on_last = 0;
      busy_seen = 0; cmdv_seen = 0;
      log_addr.delete(); log_len.delete();
   endtask

   task automatic do_start(input logic [63:0] a, input logic [31:0] len);
      @(negedge clk);
      start = 1'b1; addr_x = a; data_length = len;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL %s_done_timeout: observed no done within %0d cycles, expected done", name, budget);
      end
   endtask

   task automatic check_int(input string name, input int obs, input int exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: observed %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      compared++;
      if ({cmd_valid, d_tready, out_valid, busy, done, err} !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: observed %b expected 000000", {cmd_valid, d_tready, out_valid, busy, done, err});
      end
      compared++;
      if (out_data !== 512'd0) begin
         mismatched++;
         $display("FAIL reset_out_data: observed %h expected 0", out_data[63:0]);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_two_chunks;
      clear_mon(64'h1000_0000, 128);
      do_start(64'h1000_0000, 32'd8192);
      wait_done("two", 2000);
      compared++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL two_done_cycle: observed busy=%b out_valid=%b expected 1 1", busy, out_valid);
      end
      @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL two_busy_after: observed %b expected 0", busy);
      end
      repeat (3) @(negedge clk);
      check_int("two_cmd_count", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         compared++;
         if (log_addr[0] !== 64'h1000_0000 || log_len[0] !== 32'd4096) begin
            mismatched++;
            $display("FAIL two_cmd0: observed %h/%0d expected 10000000/4096", log_addr[0], log_len[0]);
         end
         compared++;
         if (log_addr[1] !== 64'h1000_1000 || log_len[1] !== 32'd4096) begin
            mismatched++;
            $display("FAIL two_cmd1: observed %h/%0d expected 10001000/4096", log_addr[1], log_len[1]);
         end
      end
      check_int("two_beats", out_beats, 128);
      check_int("two_data_bad", data_bad, 0);
      check_int("two_done_cnt", done_cnt, 1);
      check_int("two_done_on_last", done_on_last, 1);
   endtask

   task automatic test_short_tail;
      clear_mon(64'h2000_0000, 65);
      do_start(64'h2000_0000, 32'd4160);
      wait_done("tail", 2000);
      repeat (3) @(negedge clk);
      check_int("tail_cmd_count", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         compared++;
         if (log_addr[1] !== 64'h2000_1000 || log_len[1] !== 32'd64) begin
            mismatched++;
            $display("FAIL tail_cmd1: observed %h/%0d expected 20001000/64", log_addr[1], log_len[1]);
         end
      end
      check_int("tail_beats", out_beats, 65);
      check_int("tail_data_bad", data_bad, 0);
      check_int("tail_done_on_last", done_on_last, 1);

      clear_mon(64'h2100_0000, 1);
      do_start(64'h2100_0000, 32'h47);
      wait_done("mask", 500);
      repeat (3) @(negedge clk);
      check_int("mask_cmd_count", log_addr.size(), 1);
      if (log_len.size() == 1) check_int("mask_cmd_len", int'(log_len[0]), 64);
      check_int("mask_beats", out_beats, 1);
      check_int("mask_data_bad", data_bad, 0);
   endtask

   task automatic test_zero_len;
      clear_mon(64'h2200_0000, 0);
      do_start(64'h2200_0000, 32'd0);
      compared++;
      if (done !== 1'b0) begin
         mismatched++;
         $display("FAIL zero_done_early: observed %b expected 0", done);
      end
      @(negedge clk);
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL zero_done_at_2: observed %b expected 1", done);
      end
      repeat (4) @(negedge clk);
      check_int("zero_busy_seen", busy_seen, 0);
      check_int("zero_cmdv_seen", cmdv_seen, 0);
      check_int("zero_done_cnt", done_cnt, 1);
   endtask

   task automatic test_credit_stall;
      clear_mon(64'h3000_0000, 512);
      almost_full = 1'b1;
      do_start(64'h3000_0000, 32'd32768);
      repeat (600) @(negedge clk);
      check_int("stall_cmd_count", log_addr.size(), 4);
      compared++;
      if (cmd_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL stall_cmd_valid: observed %b expected 0", cmd_valid);
      end
      check_int("stall_beats_out", out_beats, 0);
      almost_full = 1'b0;
      wait_done("stall", 3000);
      repeat (3) @(negedge clk);
      check_int("stall_cmd_total", log_addr.size(), 8);
      check_int("stall_beats", out_beats, 512);
      check_int("stall_data_bad", data_bad, 0);
      check_int("stall_done_on_last", done_on_last, 1);
   endtask

   task automatic test_reset_mid;
      bit got2 = 1'b0;
      clear_mon(64'h4000_0000, 128);
      do_start(64'h4000_0000, 32'd8192);
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (log_addr.size() >= 2) begin got2 = 1'b1; break; end
      end
      compared++;
      if (!got2) begin
         mismatched++;
         $display("FAIL mid_second_cmd: observed %0d cmds expected 2", log_addr.size());
      end
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      compared++;
      if ({cmd_valid, d_tready, out_valid, busy, done, err} !== 6'b0) begin
         mismatched++;
         $display("FAIL mid_reset_ctrl: observed %b expected 000000", {cmd_valid, d_tready, out_valid, busy, done, err});
      end
      compared++;
      if (out_data !== 512'd0) begin
         mismatched++;
         $display("FAIL mid_reset_data: observed %h expected 0", out_data[63:0]);
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      clear_mon(64'h4100_0000, 1);
      do_start(64'h4100_0000, 32'd64);
      wait_done("mid_restart", 500);
      repeat (3) @(negedge clk);
      check_int("mid_restart_cmds", log_addr.size(), 1);
      check_int("mid_restart_beats", out_beats, 1);
      check_int("mid_restart_data_bad", data_bad, 0);
   endtask

`ifdef HBM_FETCH_LAST_CHECK_EN
   task automatic test_last_err;
      clear_mon(64'h5000_0000, 64);
      compared++;
      if (err !== 1'b0) begin
         mismatched++;
         $display("FAIL lerr_before: observed %b expected 0", err);
      end
      inject_last_at = 10;
      do_start(64'h5000_0000, 32'd4096);
      wait_done("lerr", 1000);
      inject_last_at = -1;
      compared++;
      if (err !== 1'b1) begin
         mismatched++;
         $display("FAIL lerr_set: observed %b expected 1", err);
      end
      check_int("lerr_data_bad", data_bad, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      compared++;
      if (err !== 1'b0) begin
         mismatched++;
         $display("FAIL lerr_reset: observed %b expected 0", err);
      end
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask
`else
   task automatic test_last_err;
      check_int("err_never_set", err_seen, 0);
   endtask
`endif

   initial begin
      cmd_ready = 1'b1; almost_full = 1'b0;
      start = 1'b0; addr_x = '0; data_length = '0;
      test_reset();
      test_two_chunks();
      test_short_tail();
      test_zero_len();
      test_credit_stall();
      test_reset_mid();
      test_last_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
